// File: rtl/decode_pipe_pkg.sv
// decode_pipe_pkg: shared RV32I opcodes, format enum, buffer states and decoded-bundle type
package decode_pipe_pkg;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_SYS   = 7'h73;
  localparam logic [6:0] OP_FENCE = 7'h0F;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL} insn_fmt_e;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] imm;
    insn_fmt_e   fmt;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_we;
    logic        illegal;
  } dec_t;
  localparam dec_t NOP_DEC = '{insn: NOP, imm: 32'h0, fmt: FMT_I, rs1_used: 1'b1,
                               rs2_used: 1'b0, rd_we: 1'b0, illegal: 1'b0};
  // Opcodes whose low bits are not 2'b11 never match the map, so they land in FMT_ILL too.
  function automatic insn_fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_R:                                      return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS, OP_FENCE: return FMT_I;
      OP_STORE:                                  return FMT_S;
      OP_BR:                                     return FMT_B;
      OP_LUI, OP_AUIPC:                          return FMT_U;
      OP_JAL:                                    return FMT_J;
      default:                                   return FMT_ILL;
    endcase
  endfunction
endpackage

// File: rtl/decode_pipe_igen.sv
// decode_pipe_igen: combinational sign-extended immediate generator
module decode_pipe_igen
  import decode_pipe_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [31:7] bits_i,
  output logic [31:0] imm_o
);
  insn_fmt_e fmt;
  assign fmt = fmt_of(opcode_i);
  // Select the immediate layout of the format; R and illegal carry no immediate.
  always_comb
    imm_o = fmt == FMT_I ? {{20{bits_i[31]}}, bits_i[31:20]} :
            fmt == FMT_S ? {{20{bits_i[31]}}, bits_i[31:25], bits_i[11:7]} :
            fmt == FMT_B ? {{19{bits_i[31]}}, bits_i[31], bits_i[7], bits_i[30:25], bits_i[11:8], 1'b0} :
            fmt == FMT_U ? {bits_i[31:12], 12'b0} :
            fmt == FMT_J ? {{11{bits_i[31]}}, bits_i[31], bits_i[19:12], bits_i[20], bits_i[30:21], 1'b0} :
                           32'h0;
endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: registered flow-controlled RV32I decode stage with optional skid entry
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int              DWIDTH   = 32,
  parameter int              AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 'h0100_0000,
  parameter bit              SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        shamt_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic [2:0]        fmt_o,
  output logic              rs1_used_o,
  output logic              rs2_used_o,
  output logic              rd_we_o,
  output logic              illegal_o
);
  state_e            state_q, state_d;
  dec_t              out_q, out_d, skid_q, skid_d, dec_in;
  logic [AWIDTH-1:0] opc_q, opc_d, spc_q, spc_d;
  logic [31:0]       imm_in;
  insn_fmt_e         fmt_in;
  logic              acc, deq;

  decode_pipe_igen u_igen (.opcode_i(insn_i[6:0]), .bits_i(insn_i[31:7]), .imm_o(imm_in));

  assign fmt_in      = fmt_of(insn_i[6:0]);
  assign out_valid_o = state_q != ST_EMPTY;
  assign in_ready_o  = SKID ? state_q != ST_TWO : (state_q == ST_EMPTY || out_ready_i);
  assign acc         = in_valid_i && in_ready_o;
  assign deq         = out_valid_o && out_ready_i;

  // Classify the incoming word and build the bundle that will be registered.
  always_comb
    dec_in = '{insn: insn_i, imm: imm_in, fmt: fmt_in,
               rs1_used: fmt_in inside {FMT_R, FMT_I, FMT_S, FMT_B},
               rs2_used: fmt_in inside {FMT_R, FMT_S, FMT_B},
               rd_we: fmt_in inside {FMT_R, FMT_I, FMT_U, FMT_J} && insn_i[11:7] != 5'd0,
               illegal: fmt_in == FMT_ILL};

  // Buffer occupancy and data movement; emptied slots are reloaded with the NOP bundle.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    opc_d   = opc_q;
    spc_d   = spc_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      out_d   = NOP_DEC;
      opc_d   = BASEADDR;
      skid_d  = NOP_DEC;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) begin
          state_d = ST_ONE;
          out_d   = dec_in;
          opc_d   = pc_i;
        end
        ST_ONE: if (acc && deq) begin
          out_d = dec_in;
          opc_d = pc_i;
        end else if (acc) begin
          state_d = ST_TWO;
          skid_d  = dec_in;
          spc_d   = pc_i;
        end else if (deq) begin
          state_d = ST_EMPTY;
          out_d   = NOP_DEC;
          opc_d   = BASEADDR;
        end
        default: if (deq) begin
          state_d = ST_ONE;
          out_d   = skid_q;
          opc_d   = spc_q;
          skid_d  = NOP_DEC;
        end
      endcase
    end
  end

  // State and data registers, cleared to the empty NOP bundle on reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_EMPTY;
      out_q   <= NOP_DEC;
      skid_q  <= NOP_DEC;
      opc_q   <= BASEADDR;
      spc_q   <= BASEADDR;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      opc_q   <= opc_d;
      spc_q   <= spc_d;
    end

  assign pc_o       = opc_q;
  assign insn_o     = out_q.insn;
  assign opcode_o   = out_q.insn[6:0];
  assign rd_o       = out_q.insn[11:7];
  assign funct3_o   = out_q.insn[14:12];
  assign rs1_o      = out_q.insn[19:15];
  assign rs2_o      = out_q.insn[24:20];
  assign funct7_o   = out_q.insn[31:25];
  assign shamt_o    = out_q.insn[24:20];
  assign imm_o      = out_q.imm;
  assign fmt_o      = out_q.fmt;
  assign rs1_used_o = out_q.rs1_used;
  assign rs2_used_o = out_q.rs2_used;
  assign rd_we_o    = out_q.rd_we;
  assign illegal_o  = out_q.illegal;
endmodule
